// File: rtl/mult_pkg.sv
// Shared types and defaults for the sequential signed multiplier.
package mult_pkg;

  localparam int DEFAULT_DW = 8;
  localparam int DEFAULT_CNT_W = $clog2(DEFAULT_DW);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    CALC = 3'd2,
    FIX  = 3'd3,
    DONE = 3'd4
  } state_e;

endpackage

// File: rtl/signed_mult_seq_if.sv
// Operand/result handshake between the operand registers and the multiplier.
interface signed_mult_seq_if
  import mult_pkg::*;
#(
  parameter int DW = DEFAULT_DW
);
  logic            start;
  logic [DW-1:0]   multiplicand;
  logic [DW-1:0]   multiplier;
  logic            ready;
  logic            done;
  logic            sign;
  logic [2*DW-1:0] result;

  modport master (
    output start, multiplicand, multiplier,
    input  ready, done, sign, result
  );

  modport slave (
    input  start, multiplicand, multiplier,
    output ready, done, sign, result
  );
endinterface

// File: rtl/a2_complement.sv
// Two's-complement negation of an N-bit value.
module a2_complement #(
  parameter int N = 8
) (
  input  logic [N-1:0] din,
  output logic [N-1:0] dout
);
  assign dout = ~din + N'(1);
endmodule

// File: rtl/signed_mult_seq.sv
// Sequential signed multiplier: magnitudes, DW-step shift-add, sign fix-up.
// Optional EARLY_TERM_EN stops the shift-add once the remaining multiplier bits are zero.
module signed_mult_seq
  import mult_pkg::*;
#(
  parameter int DW = DEFAULT_DW
) (
  input logic              clk,
  input logic              rst_n,
  signed_mult_seq_if.slave bus
);
  localparam int CW = $clog2(DW);
  localparam int PW = 2 * DW;

  state_e        state_q, state_d;
  logic [DW-1:0] a_q, a_d, b_q, b_d;
  logic [DW-1:0] mag_a_q, mag_a_d, mag_b_q, mag_b_d;
  logic          neg_q, neg_d;
  logic [PW-1:0] acc_q, acc_d;
  logic [PW-1:0] result_q, result_d;
  logic          sign_q, sign_d;
  logic [CW-1:0] count_q, count_d;

  logic [DW-1:0] comp_a, comp_b;
  logic [PW-1:0] comp_acc;
  logic          last_iter;
  logic          early_exit;

  a2_complement #(.N(DW)) u_comp_a   (.din(a_q),   .dout(comp_a));
  a2_complement #(.N(DW)) u_comp_b   (.din(b_q),   .dout(comp_b));
  a2_complement #(.N(PW)) u_comp_acc (.din(acc_q), .dout(comp_acc));

  assign last_iter = (count_q == CW'(DW - 1));

`ifdef EARLY_TERM_EN
  assign early_exit = ((mag_b_q >> count_q) == '0);
`else
  assign early_exit = 1'b0;
`endif

  always_comb begin
    // NOTE: every _d defaults to its _q first so no path through the case infers a latch.
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    mag_a_d  = mag_a_q;
    mag_b_d  = mag_b_q;
    neg_d    = neg_q;
    acc_d    = acc_q;
    result_d = result_q;
    sign_d   = sign_q;
    count_d  = count_q;

    unique case (state_q)
      IDLE, DONE: begin
        if (bus.start) begin
          a_d     = bus.multiplicand;
          b_d     = bus.multiplier;
          state_d = LOAD;
        end else begin
          state_d = IDLE;
        end
      end
      LOAD: begin
        mag_a_d = a_q[DW-1] ? comp_a : a_q;
        mag_b_d = b_q[DW-1] ? comp_b : b_q;
        neg_d   = a_q[DW-1] ^ b_q[DW-1];
        acc_d   = '0;
        count_d = '0;
        state_d = CALC;
      end
      CALC: begin
        if (early_exit) begin
          state_d = FIX;
        end else begin
          if (mag_b_q[count_q]) begin
            acc_d = acc_q + ({{DW{1'b0}}, mag_a_q} << count_q);
          end
          if (last_iter) begin
            state_d = FIX;
          end else begin
            count_d = count_q + CW'(1);
          end
        end
      end
      FIX: begin
        // A zero product stays positive even when the operand signs differ.
        if (neg_q && (acc_q != '0)) begin
          result_d = comp_acc;
          sign_d   = 1'b1;
        end else begin
          result_d = acc_q;
          sign_d   = 1'b0;
        end
        state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      mag_a_q  <= '0;
      mag_b_q  <= '0;
      neg_q    <= 1'b0;
      acc_q    <= '0;
      result_q <= '0;
      sign_q   <= 1'b0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      mag_a_q  <= mag_a_d;
      mag_b_q  <= mag_b_d;
      neg_q    <= neg_d;
      acc_q    <= acc_d;
      result_q <= result_d;
      sign_q   <= sign_d;
      count_q  <= count_d;
    end
  end

  assign bus.ready  = (state_q == IDLE) || (state_q == DONE);
  assign bus.done   = (state_q == DONE);
  assign bus.sign   = sign_q;
  assign bus.result = result_q;

endmodule

// File: tb/tb_signed_mult_seq.sv
// Self-checking bench for signed_mult_seq against an arithmetic reference product.
`timescale 1ns/1ps
module tb_signed_mult_seq;
  localparam int DW = 8;
  localparam int PW = 2 * DW;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  signed_mult_seq_if #(.DW(DW)) bus ();
  signed_mult_seq #(.DW(DW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int n_cmp = 0;
  int n_bad = 0;

  // Reference: plain signed integer multiplication.
  function automatic logic [PW-1:0] ref_prod(input logic [DW-1:0] a, input logic [DW-1:0] b);
    int p;
    p = $signed(a) * $signed(b);
    return p[PW-1:0];
  endfunction

  function automatic logic ref_sign(input logic [DW-1:0] a, input logic [DW-1:0] b);
    int p;
    p = $signed(a) * $signed(b);
    return (p < 0);
  endfunction

  // Edges from the accepting edge to the edge entering DONE.
  function automatic int ref_lat(input logic [DW-1:0] b);
    int m;
    int nb;
    int calc;
    m = $signed(b);
    if (m < 0) m = -m;
    nb = 0;
    while (m > 0) begin
      nb++;
      m = m >> 1;
    end
`ifdef EARLY_TERM_EN
    calc = (nb + 1 < DW) ? nb + 1 : DW;
`else
    calc = DW + 0 * nb;
`endif
    return calc + 2;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(input string tag, output bit ok);
    int waited = 0;
    while (!bus.ready && waited < 50) begin
      tick();
      waited++;
    end
    ok = bus.ready;
    if (!ok) begin
      n_cmp++; n_bad++;
      $display("FAIL %s ready_timeout: ready=%b required=1", tag, bus.ready);
    end
  endtask

  task automatic run_op(input logic [DW-1:0] a, input logic [DW-1:0] b, input bit noise,
                        input string tag);
    bit ok;
    bit got;
    int t;
    logic [PW-1:0] exp_r;
    logic exp_s;
    int exp_t;
    exp_r = ref_prod(a, b);
    exp_s = ref_sign(a, b);
    exp_t = ref_lat(b);
    wait_ready(tag, ok);
    if (!ok) return;
    bus.start = 1'b1;
    bus.multiplicand = a;
    bus.multiplier = b;
    tick();
    bus.start = 1'b0;
    bus.multiplicand = DW'($urandom);
    bus.multiplier = DW'($urandom);
    got = 1'b0;
    t = 0;
    while (!got && t < 40) begin
      tick();
      t++;
      if (noise) bus.start = (t == 1);
      if (bus.done) got = 1'b1;
    end
    n_cmp++;
    if (!got || t !== exp_t) begin
      n_bad++;
      $display("FAIL %s latency: got=%0d required=%0d (a=%0d b=%0d)", tag, t, exp_t,
               $signed(a), $signed(b));
    end
    n_cmp++;
    if (bus.result !== exp_r) begin
      n_bad++;
      $display("FAIL %s result: got=%h required=%h (a=%0d b=%0d)", tag, bus.result, exp_r,
               $signed(a), $signed(b));
    end
    n_cmp++;
    if (bus.sign !== exp_s) begin
      n_bad++;
      $display("FAIL %s sign: got=%b required=%b", tag, bus.sign, exp_s);
    end
    tick();
    n_cmp++;
    if (bus.done !== 1'b0 || bus.result !== exp_r || bus.ready !== 1'b1) begin
      n_bad++;
      $display("FAIL %s after_done: done=%b result=%h ready=%b required done=0 result=%h ready=1",
               tag, bus.done, bus.result, bus.ready, exp_r);
    end
  endtask

  task automatic test_reset();
    bus.start = 1'b0;
    bus.multiplicand = '0;
    bus.multiplier = '0;
    rst_n = 1'b0;
    #12;
    n_cmp++;
    if (bus.ready !== 1'b1 || bus.done !== 1'b0 || bus.result !== '0 || bus.sign !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_state: ready=%b done=%b result=%h sign=%b required 1 0 0000 0",
               bus.ready, bus.done, bus.result, bus.sign);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_directed();
    run_op(8'sd7,    -8'sd3,   1'b0, "d_7x-3");
    run_op(8'h80,    8'h80,    1'b0, "d_-128x-128");
    run_op(8'h80,    8'sd127,  1'b0, "d_-128x127");
    run_op(-8'sd5,   8'sd0,    1'b0, "d_-5x0");
    run_op(8'sd0,    -8'sd5,   1'b0, "d_0x-5");
    run_op(-8'sd1,   -8'sd1,   1'b0, "d_-1x-1");
    run_op(8'sd127,  8'sd127,  1'b0, "d_127x127");
    run_op(8'sd3,    8'h80,    1'b0, "d_3x-128");
  endtask

  task automatic test_ignore_start();
    run_op(8'sd7,   -8'sd3,  1'b1, "noise_7x-3");
    run_op(-8'sd100, 8'sd99, 1'b1, "noise_-100x99");
    run_op(-8'sd5,   8'sd0,  1'b1, "noise_-5x0");
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] qa[$];
    logic [DW-1:0] qb[$];
    bit ok;
    int k;
    int t;
    int prev;
    int exp_gap;
    for (int i = 0; i < 5; i++) begin
      qa.push_back(DW'($urandom));
      qb.push_back(DW'($urandom));
    end
    qa.push_back(-8'sd5);
    qb.push_back(8'sd0);
    qa.push_back(8'h80);
    qb.push_back(8'h80);
    wait_ready("b2b", ok);
    if (!ok) return;
    bus.start = 1'b1;
    bus.multiplicand = qa[0];
    bus.multiplier = qb[0];
    tick();
    k = 0;
    t = 0;
    prev = 0;
    while (k < qa.size() && t < 200) begin
      tick();
      t++;
      if (bus.done) begin
        exp_gap = (k == 0) ? ref_lat(qb[k]) : ref_lat(qb[k]) + 1;
        n_cmp++;
        if (t - prev !== exp_gap) begin
          n_bad++;
          $display("FAIL b2b_gap[%0d]: got=%0d required=%0d", k, t - prev, exp_gap);
        end
        n_cmp++;
        if (bus.result !== ref_prod(qa[k], qb[k]) || bus.sign !== ref_sign(qa[k], qb[k])) begin
          n_bad++;
          $display("FAIL b2b_result[%0d]: got=%h/%b required=%h/%b", k, bus.result, bus.sign,
                   ref_prod(qa[k], qb[k]), ref_sign(qa[k], qb[k]));
        end
        prev = t;
        k++;
        if (k < qa.size()) begin
          bus.multiplicand = qa[k];
          bus.multiplier = qb[k];
        end else begin
          bus.start = 1'b0;
        end
      end
    end
    bus.start = 1'b0;
    n_cmp++;
    if (k !== qa.size()) begin
      n_bad++;
      $display("FAIL b2b_count: got=%0d required=%0d", k, qa.size());
    end
    tick();
  endtask

  task automatic test_reset_mid();
    bit ok;
    run_op(8'sd7, -8'sd3, 1'b0, "pre_reset");
    wait_ready("reset_mid", ok);
    if (!ok) return;
    bus.start = 1'b1;
    bus.multiplicand = 8'sd100;
    bus.multiplier = 8'sd77;
    tick();
    bus.start = 1'b0;
    tick();
    tick();
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (bus.ready !== 1'b1 || bus.done !== 1'b0 || bus.result !== '0 || bus.sign !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_async: ready=%b done=%b result=%h sign=%b required 1 0 0000 0",
               bus.ready, bus.done, bus.result, bus.sign);
    end
    tick();
    tick();
    n_cmp++;
    if (bus.ready !== 1'b1 || bus.done !== 1'b0 || bus.result !== '0) begin
      n_bad++;
      $display("FAIL reset_hold: ready=%b done=%b result=%h required 1 0 0000",
               bus.ready, bus.done, bus.result);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    run_op(-8'sd9, 8'sd13, 1'b0, "post_reset");
  endtask

  task automatic test_random();
    for (int i = 0; i < 40; i++) begin
      run_op(DW'($urandom), DW'($urandom), 1'($urandom), $sformatf("rand%0d", i));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_directed();
    test_ignore_start();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
